// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and parity mode constants.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: bit_end marks the last clock of each CLKS_PER_BIT-long bit.
module uart_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_end
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign bit_end = (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || bit_end) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with parameterised frame format and a one-entry holding register
// so a byte queued mid-frame follows the current stop bit with no idle gap.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_data_valid,
  input  logic [DATA_BITS-1:0] i_data_byte,
  output logic                 o_ready,
  output logic                 o_tx,
  output logic                 o_active,
  output logic                 o_done
);

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
    $error("uart_tx_fifo: CLKS_PER_BIT must be 2..65535");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_fifo: DATA_BITS must be 5..9");
  end
  if (PARITY > PAR_EVEN) begin : g_bad_parity
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end

  localparam logic [3:0] LastData  = 4'(DATA_BITS - 1);
  localparam logic [3:0] LastStop  = 4'(STOP_BITS - 1);
  localparam bit         HasParity = (PARITY != PAR_NONE);

  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return (PARITY == PAR_ODD) ? ~^d : ^d;
  endfunction

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [3:0]           idx_q, idx_d;
  logic                 hold_valid_q, hold_valid_d;
  logic                 par_q, par_d;
  logic                 done_q, done_d;
  logic                 accept, consume, bit_end;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .rst    (rst),
    .restart(state_q == StIdle),
    .bit_end(bit_end)
  );

  // Accept only into an empty hold, so it can never collide with a consume.
  assign accept = i_data_valid && !hold_valid_q;

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    shift_d      = shift_q;
    idx_d        = idx_q;
    par_d        = par_q;
    done_d       = 1'b0;
    consume      = 1'b0;

    if (accept) begin
      hold_d       = i_data_byte;
      hold_valid_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (hold_valid_q) begin
          consume = 1'b1;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          idx_d   = '0;
        end
      end
      StData: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 1'b1;
          if (idx_q == LastData) begin
            idx_d   = '0;
            state_d = HasParity ? StParity : StStop;
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
          idx_d   = '0;
        end
      end
      StStop: begin
        if (bit_end) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == LastStop) begin
            done_d = 1'b1;
            idx_d  = '0;
            if (hold_valid_q) begin
              consume = 1'b1;
            end else begin
              state_d = StIdle;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (consume) begin
      state_d      = StStart;
      shift_d      = hold_q;
      par_d        = parity_of(hold_q);
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      shift_q      <= '0;
      idx_q        <= '0;
      par_q        <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      shift_q      <= shift_d;
      idx_q        <= idx_d;
      par_q        <= par_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    case (state_q)
      StStart:  o_tx = 1'b0;
      StData:   o_tx = shift_q[0];
      StParity: o_tx = par_q;
      default:  o_tx = 1'b1;
    endcase
  end

  assign o_ready  = !hold_valid_q;
  assign o_active = (state_q != StIdle);
  assign o_done   = done_q;

endmodule
